// File: rtl/mux_share_arbiter.sv
// Shares the 3-bit LEDR data channel between two switch requesters with a
// clocked grant FSM, a minimum grant tenure and round-robin/fixed-priority policy.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no grant, LEDR data forced to 0
//   GNT_A | requester A owns the channel, LEDR[2:0] follows swS[2:0]
//   GNT_B | requester B owns the channel, LEDR[2:0] follows swS[5:3]
module mux_share_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  logic          rst_n;
  logic [9:0]    sw_meta_q, sw_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic [2:0]    m_q, m_d;
  logic          req_a, req_b, mode, expired;
  logic          unused_inputs;

  assign rst_n = KEY[0];
  assign unused_inputs = ^{KEY[3:1], sw_s_q[6]};

  assign req_a   = sw_s_q[7];
  assign req_b   = sw_s_q[8];
  assign mode    = sw_s_q[9];
  assign expired = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = expired ? cnt_q : cnt_q - CW'(1);

    unique case (state_q)
      IDLE: begin
        if (req_a && req_b)
          state_d = (mode || !ptr_q) ? GNT_A : GNT_B;
        else if (req_a)
          state_d = GNT_A;
        else if (req_b)
          state_d = GNT_B;
      end
      GNT_A: begin
        // In fixed-priority mode A keeps the channel while it still asks for it.
        if (expired) begin
          if (req_b && !(req_a && mode)) state_d = GNT_B;
          else if (!req_a)               state_d = IDLE;
        end
      end
      GNT_B: begin
        if (expired) begin
          if (req_a)       state_d = GNT_A;
          else if (!req_b) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      if (state_d == GNT_A) begin
        cnt_d = CNT_LOAD;
        ptr_d = 1'b1;
      end else if (state_d == GNT_B) begin
        cnt_d = CNT_LOAD;
        ptr_d = 1'b0;
      end
    end

    unique case (state_d)
      GNT_A:   m_d = sw_s_q[2:0];
      GNT_B:   m_d = sw_s_q[5:3];
      default: m_d = 3'b000;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b0;
      m_q       <= 3'b000;
    end else begin
      sw_meta_q <= SW;
      sw_s_q    <= sw_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      m_q       <= m_d;
    end
  end

  assign LEDR = {3'b000, ptr_q, (state_q != IDLE), (state_q == GNT_B),
                 (state_q == GNT_A), m_q};

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench for mux_share_arbiter: a cycle model predicts LEDR for every
// driven switch pattern; predictions are queued and compared after each edge.
module tb_mux_share_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic [3:0] key_drv;
  logic [9:0] sw_drv;
  logic [9:0] ledr;

  int n_chk;
  int n_bad;

  logic [9:0] exp_q[$];

  // reference model state: st 0=idle 1=A 2=B, el = cycles spent in current tenure
  logic [9:0] m_s1, m_s2;
  int         m_st;
  int         m_el;
  logic       m_ptr;
  logic [2:0] m_m;

  mux_share_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .CLOCK_50(clk),
    .KEY     (key_drv),
    .SW      (sw_drv),
    .LEDR    (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1  = '0;
    m_s2  = '0;
    m_st  = 0;
    m_el  = 0;
    m_ptr = 1'b0;
    m_m   = 3'b000;
    exp_q.delete();
  endtask

  // Advances the model across one rising edge with sw as the raw input
  // present before that edge; returns the LEDR value expected after it.
  task automatic model_step(input logic [9:0] sw, output logic [9:0] led);
    logic ra, rb, md, own, oth;
    int   nxt;
    ra  = m_s2[7];
    rb  = m_s2[8];
    md  = m_s2[9];
    nxt = m_st;
    if (m_st == 0) begin
      if (ra && rb)  nxt = (md || !m_ptr) ? 1 : 2;
      else if (ra)   nxt = 1;
      else if (rb)   nxt = 2;
    end else if (m_el >= HOLD) begin
      own = (m_st == 1) ? ra : rb;
      oth = (m_st == 1) ? rb : ra;
      if (oth && !(m_st == 1 && own && md)) nxt = 3 - m_st;
      else if (own)                         nxt = m_st;
      else                                  nxt = 0;
    end
    if (nxt == 0) begin
      m_el = 0;
    end else if (nxt != m_st) begin
      m_el  = 1;
      m_ptr = (nxt == 1);
    end else begin
      m_el++;
    end
    m_m  = (nxt == 1) ? m_s2[2:0] : (nxt == 2) ? m_s2[5:3] : 3'b000;
    m_st = nxt;
    m_s2 = m_s1;
    m_s1 = sw;
    led  = {3'b000, m_ptr, (m_st != 0), (m_st == 2), (m_st == 1), m_m};
  endtask

  task automatic step(input logic [9:0] sw);
    logic [9:0] e;
    @(negedge clk);
    sw_drv = sw;
    model_step(sw, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 10'h3ff, 10'h000);
    end else begin
      check_eq("ledr", ledr, exp_q.pop_front());
    end
    check_eq("both_gnt", {9'b0, ledr[3] & ledr[4]}, 10'h000);
  endtask

  task automatic step_n(input logic [9:0] sw, input int n);
    for (int i = 0; i < n; i++) step(sw);
  endtask

  // Holds reset for a few edges and releases it just after a rising edge.
  task automatic apply_reset(input logic [9:0] sw, input int cycles);
    key_drv[0] = 1'b0;
    sw_drv     = sw;
    model_reset();
    #1;
    check_eq("rst_async", ledr, 10'h000);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold", ledr, 10'h000);
    end
    key_drv[0] = 1'b1;
  endtask

  initial begin
    n_chk   = 0;
    n_bad   = 0;
    key_drv = 4'b1110;
    sw_drv  = 10'h3ff;
    model_reset();

    // reset with all switches up and clock running
    apply_reset(10'h3ff, 4);

    // single one-cycle request from A, round-robin mode
    step_n(10'b00_0000_0101, 2);
    step(10'b00_1000_0101);
    step_n(10'b00_0000_0101, 10);
    check_eq("single_idle", ledr, 10'h040);

    // round-robin tie, A=3 B=6
    apply_reset(10'h000, 2);
    step_n(10'b01_1011_0011, 20);
    check_eq("rr_busy", {9'b0, ledr[5]}, 10'h001);

    // fixed priority, then A drops, then A returns, then async reset mid grant
    apply_reset(10'h000, 2);
    step_n(10'b11_1001_0001, 12);
    check_eq("fp_hold_a", ledr[4:3], 10'b01);
    step_n(10'b11_0001_0001, 8);
    step_n(10'b11_1001_0001, 8);
    check_eq("fp_back_a", ledr[4:3], 10'b01);
    #1;
    apply_reset(10'h3ff, 2);

    // live data on B
    step_n(10'b01_0001_0000, 6);
    check_eq("live_b_010", ledr, 10'h032);
    step_n(10'b01_0011_1000, 8);
    check_eq("live_b_111", ledr, 10'h037);

    // mode switch during a B tenure
    apply_reset(10'h000, 2);
    step_n(10'b01_1010_1101, 9);
    step_n(10'b11_1010_1101, 16);
    check_eq("mode_sw_a", ledr[4:3], 10'b01);

    // random traffic
    apply_reset(10'h000, 2);
    begin
      logic [9:0] r;
      r = 10'h000;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) r = 10'($urandom_range(0, 1023));
        step(r);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_share_arbiter.md
# mux_share_arbiter

Two-requester arbiter that shares the 3-bit switch-selected output channel on LEDR between requester A (SW[2:0]) and requester B (SW[5:3]). It replaces the manual SW[9] select of the lab's 2-to-1 mux with a synchronized, clocked grant FSM. The FSM supports round-robin or fixed-priority arbitration and a minimum grant tenure, so the LEDs do not flicker. It is top-level on the DE-series board and is driven by CLOCK_50, KEY and SW.

## Interface
- HOLD_CYCLES, default 50_000_000: minimum grant tenure in clock cycles, ≥1. The bench uses 4.
- CLOCK_50  input  1  board clock; all state changes on the rising edge.
- KEY  input  4  KEY[0] is the reset: asynchronous, active-low. KEY[3:1] are unused.
- SW  input  10  the bits are used as follows:
  - SW[2:0]: data A.
  - SW[5:3]: data B.
  - SW[6]: unused.
  - SW[7]: request A.
  - SW[8]: request B.
  - SW[9]: mode; 0 = round-robin, 1 = fixed priority with A high.
- LEDR  output  10  the bits are driven as follows:
  - [2:0]: muxed data M.
  - [3]: grant A.
  - [4]: grant B.
  - [5]: busy (= grant A | grant B).
  - [6]: round-robin pointer; 0 means A wins the next tie.
  - [9:7]: tied to 0.

## Operation
- Input synchronizer:
  - SW[9:0] passes through a 2-flop synchronizer (swS).
  - All decisions use swS only; raw SW never reaches logic.
  - KEY[0] is not synchronized.
- FSM states are IDLE, GNT_A and GNT_B. State, counter, pointer and M are all registers, and LEDR is a direct decode of them.
- Hold counter:
  - Width is $clog2(HOLD_CYCLES+1).
  - It is loaded with HOLD_CYCLES-1 on every entry to GNT_A or GNT_B.
  - It decrements by 1 per cycle while nonzero and saturates at 0. "Expired" means count == 0.
- IDLE:
  - Only reqA → GNT_A. Only reqB → GNT_B. No request → stay in IDLE.
  - Both requesting, mode=1 → GNT_A.
  - Both requesting, mode=0 → GNT_A if ptr=0, else GNT_B.
- GNT_X, not expired: stay in GNT_X regardless of requests. Dropping the request does not shorten tenure.
- GNT_X, expired — evaluate in this order:
  1. The other requester is requesting and wins by policy → go directly to GNT_other. There is no IDLE cycle, and the counter reloads.
  2. Else, own request is still asserted → stay.
  3. Else → IDLE.
- Policy when expired and both are requesting:
  - mode=0: always hand over to the other requester (strict alternation).
  - mode=1: GNT_A stays; GNT_B hands over to A.
- Only the other requester requesting → hand over in either mode.
- Pointer: on every entry to GNT_A, ptr ← 1; on entry to GNT_B, ptr ← 0. The pointer is updated in both modes.
- Mode changes take effect at the next arbitration decision (IDLE or expiry). They never abort a tenure.
- M (registered), updated every cycle:
  - Next state GNT_A → M ← swS[2:0].
  - Next state GNT_B → M ← swS[5:3].
  - Next state IDLE → M ← 0.
- Data changes during a grant propagate live.

## Timing
- Reset (KEY[0]=0):
  - Immediately, with no clock edge required: state=IDLE, counter=0, ptr=0, M=0, synchronizer flops=0.
  - Hence LEDR = 10'b0.
  - Reset mid-grant drops the grant at once.
  - After release, the first decision uses swS, so 2 edges must refill the synchronizer.
- Latency from an SW change to LEDR: 3 rising edges (2 sync + 1 state/M register). This applies to both requests and data.
- Tenure: a grant is high for at least HOLD_CYCLES consecutive cycles.
  - Expiry is detected in cycle HOLD_CYCLES of the tenure.
  - The next state takes effect at the following edge.
- Handover: LEDR[3] and LEDR[4] swap on the same edge; busy stays 1. They are never both 1.
- HOLD_CYCLES=1: the counter is loaded with 0, so every grant cycle is an arbitration point.

## Test plan
- Reset: hold KEY[0]=0 with SW=10'h3FF and clock running → LEDR=0. Assert KEY[0]=0 mid-GNT_A → LEDR=0 before the next edge.
- Single request, mode=0, HOLD=4: SW[2:0]=3'b101, then pulse SW[7] for 1 cycle → 3 edges later LEDR[3]=1, LEDR[2:0]=101, LEDR[6]=1. This holds exactly 4 cycles, then LEDR=0 except LEDR[6]=1.
- Round-robin tie: A=3, B=6, raise SW[7] and SW[8] on the same edge → A is granted for 4 cycles (M=3), then B for 4 (M=6), then A again. LEDR[5] stays continuously 1 and the grants are never simultaneous.
- Fixed priority: SW[9]=1, both requests held → GNT_A indefinitely. Drop SW[7] → once expired, B is granted on the next edge; LEDR[3:4] swaps with no IDLE gap.
- Live data: in GNT_B, change SW[5:3] 010→111 → LEDR[2:0] changes exactly 3 edges later and the grant is unaffected.
- Mode switch mid-tenure: in GNT_B with both requesting, set SW[9]=1 → B finishes its 4-cycle tenure, then A is granted and holds while A requests.
